// File: rtl/mau_pkg.sv
// Shared encodings for the MEM-stage load/store initiator.
package mau_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;

  // Stores occupy the top three encodings.
  function automatic logic is_store(input op_type_e t);
    return (t == OP_SW) || (t == OP_SH) || (t == OP_SB);
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension, alignment check.
module lsu_align
  import mau_pkg::*;
(
  input  op_type_e           op_type,
  input  logic [1:0]         addr,
  input  logic [DATA_W-1:0]  op_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [BE_W-1:0]    be,
  output logic [DATA_W-1:0]  wdata_rep,
  output logic [DATA_W-1:0]  ld_ext,
  output logic               misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Select the addressed byte and half of the returned word.
  always_comb begin
    ld_byte = 8'(mem_rdata >> {addr, 3'b000});
    ld_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Lane enables, store replication and misalignment per access size.
  always_comb begin
    be         = 4'b1111;
    wdata_rep  = op_wdata;
    misaligned = 1'b0;
    case (op_type)
      OP_SB: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{op_wdata[7:0]}};
      end
      OP_SH: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{op_wdata[15:0]}};
        misaligned = addr[0];
      end
      OP_SW, OP_LW:        misaligned = (addr != 2'b00);
      OP_LH, OP_LHU:       misaligned = addr[0];
      default:             misaligned = 1'b0;
    endcase
  end

  // Sign/zero extension of the selected load lane.
  always_comb begin
    ld_ext = mem_rdata;
    case (op_type)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: req/ack handshake to data memory with pipeline stall.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned WORD_ADDR_LSB = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op_type,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              exc,
  output logic [1:0]        exc_code,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << WORD_ADDR_LSB) - 1);

  state_e      state;
  op_type_e    op_t;
  op_type_e    type_q;
  logic [1:0]  addr_lo_q;

  op_type_e    al_type;
  logic [1:0]  al_addr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;
  logic        al_mis;

  assign op_t = op_type_e'(op_type);

  // The aligner sees the incoming op while idle and the latched op while the access is in flight.
  always_comb begin
    al_type = (state == ST_IDLE) ? op_t : type_q;
    al_addr = (state == ST_IDLE) ? op_addr[1:0] : addr_lo_q;
  end

  lsu_align u_align (
    .op_type    (al_type),
    .addr       (al_addr),
    .op_wdata   (op_wdata),
    .mem_rdata  (mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .ld_ext     (al_ld),
    .misaligned (al_mis)
  );

  // Stall must rise in the same cycle the op is presented, so it is decoded from state.
  assign stall = (state == ST_BUSY) || ((state == ST_IDLE) && op_valid);

  // Access sequencer with registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      type_q    <= OP_LW;
      addr_lo_q <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      ld_data   <= 32'd0;
      ld_valid  <= 1'b0;
      exc       <= 1'b0;
      exc_code  <= EXC_NONE;
    end else begin
      ld_valid <= 1'b0;
      exc      <= 1'b0;
      exc_code <= EXC_NONE;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            if (al_mis) begin
              state    <= ST_FAULT;
              exc      <= 1'b1;
              exc_code <= is_store(op_t) ? EXC_ADES : EXC_ADEL;
            end else begin
              state     <= ST_BUSY;
              type_q    <= op_t;
              addr_lo_q <= op_addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= is_store(op_t);
              mem_addr  <= op_addr & ALIGN_MASK;
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!is_store(type_q)) begin
              ld_data  <= al_ld;
              ld_valid <= 1'b1;
            end
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: the driver queues expected requests, results and stall lengths; a monitor checks them.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        exc;
  logic [1:0]  exc_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          is_exc;
    logic [31:0] data;
    logic [1:0]  code;
  } ev_t;

  req_t req_q[$];
  ev_t  ev_q[$];
  int   stall_q[$];

  int checks = 0;
  int errors = 0;

  int          wait_cfg = 0;
  logic [31:0] rdata_cfg = 32'd0;
  logic        ack_m = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] last_ld = 32'd0;

  assign mem_ack   = ack_m | force_ack;
  assign mem_rdata = rdata_cfg;

  always #5 Clk = ~Clk;

  mem_access_unit #(.ADDR_W(32), .WORD_ADDR_LSB(2)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_type   (op_type),
    .op_addr   (op_addr),
    .op_wdata  (op_wdata),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .exc       (exc),
    .exc_code  (exc_code),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (from the access rules) ----------------
  function automatic bit ref_is_store(input logic [2:0] t);
    return t >= 3'd5;
  endfunction

  function automatic bit ref_mis(input logic [2:0] t, input logic [31:0] a);
    int lo;
    lo = int'(a % 4);
    if (t == 3'd0 || t == 3'd5) return lo != 0;
    if (t == 3'd1 || t == 3'd2 || t == 3'd6) return (lo % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] t, input logic [31:0] a);
    int lo;
    lo = int'(a % 4);
    if (t == 3'd7) return 4'(1 << lo);
    if (t == 3'd6) return (lo >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] t, input logic [31:0] w);
    if (t == 3'd7) return (w % 256) * 32'h0101_0101;
    if (t == 3'd6) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
    longint b, h;
    b = longint'((rd / (32'd1 << (8 * (a % 4)))) % 256);
    h = longint'((rd / (32'd1 << (16 * ((a % 4) / 2)))) % 65536);
    case (t)
      3'd3: return 32'(b >= 128 ? b - 256 : b);
      3'd4: return 32'(b);
      3'd1: return 32'(h >= 32768 ? h - 65536 : h);
      3'd2: return 32'(h);
      default: return rd;
    endcase
  endfunction

  // ---------------- memory responder ----------------
  int mcnt = 0;
  always @(posedge Clk) begin
    #1;
    if (reset || !mem_req) begin
      ack_m = 1'b0;
      mcnt  = 0;
    end else if (mcnt >= wait_cfg) begin
      ack_m = 1'b1;
      mcnt  = 0;
    end else begin
      ack_m = 1'b0;
      mcnt++;
    end
  end

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;
  req_t cur_req;
  int   run = 0;
  always @(negedge Clk) begin
    if (mem_req && !prev_req) begin
      if (req_q.size() == 0) begin
        chk("unexpected_mem_req", 32'd1, 32'd0);
      end else begin
        cur_req = req_q.pop_front();
        chk("req_we", 32'(mem_we), 32'(cur_req.we));
        chk("req_addr", mem_addr, cur_req.addr);
        chk("req_be", 32'(mem_be), 32'(cur_req.be));
        if (cur_req.we) chk("req_wdata", mem_wdata, cur_req.wdata);
      end
    end else if (mem_req) begin
      chk("hold_addr", mem_addr, cur_req.addr);
      chk("hold_be", 32'(mem_be), 32'(cur_req.be));
      if (cur_req.we) chk("hold_wdata", mem_wdata, cur_req.wdata);
    end
    prev_req = mem_req;

    if (ld_valid || exc) begin
      if (ev_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, ld_valid, exc}, 32'd0);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        chk("pulse_is_exc", 32'(exc), 32'(e.is_exc));
        chk("pulse_is_ld", 32'(ld_valid), 32'(!e.is_exc));
        if (e.is_exc) begin
          chk("exc_code", 32'(exc_code), 32'(e.code));
          chk("ld_data_hold", ld_data, last_ld);
        end else begin
          chk("ld_data", ld_data, e.data);
          last_ld = e.data;
        end
      end
    end

    if (stall) begin
      run++;
    end else if (run > 0) begin
      if (stall_q.size() == 0) chk("unexpected_stall", 32'(run), 32'd0);
      else chk("stall_len", 32'(run), 32'(stall_q.pop_front()));
      run = 0;
    end
  end

  // ---------------- driver ----------------
  // Presents one op and returns #1 after the edge where stall falls (DONE/FAULT); op_valid is left high.
  task automatic do_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                       input int waits, input logic [31:0] rd);
    int n;
    if (ref_mis(t, a)) begin
      ev_q.push_back('{is_exc: 1'b1, data: 32'd0,
                       code: ref_is_store(t) ? 2'd2 : 2'd1});
      stall_q.push_back(1);
    end else begin
      req_q.push_back('{we: ref_is_store(t), addr: a - (a % 4),
                        be: ref_be(t, a), wdata: ref_wdata(t, w)});
      stall_q.push_back(2 + waits);
      if (!ref_is_store(t))
        ev_q.push_back('{is_exc: 1'b0, data: ref_load(t, a, rd), code: 2'd0});
    end
    wait_cfg  = waits;
    rdata_cfg = rd;
    op_valid  = 1'b1;
    op_type   = t;
    op_addr   = a;
    op_wdata  = w;
    @(posedge Clk); #1;
    n = 0;
    while (stall && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 100) chk("op_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int cycles);
    op_valid = 1'b0;
    repeat (cycles) begin @(posedge Clk); #1; end
  endtask

  initial begin
    reset    = 1'b1;
    op_valid = 1'b0;
    op_type  = 3'd0;
    op_addr  = 32'd0;
    op_wdata = 32'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_ldv", 32'(ld_valid), 32'd0);
    chk("rst_exc", {30'd0, exc_code} | 32'(exc), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    idle(2);

    // Directed cases.
    do_op(3'd5, 32'h10, 32'hDEAD_BEEF, 0, 32'd0);   idle(1);
    do_op(3'd7, 32'h13, 32'h0000_00A5, 3, 32'd0);   idle(1);
    do_op(3'd3, 32'h2, 32'd0, 0, 32'h80FF_7F01);    idle(1);
    do_op(3'd4, 32'h3, 32'd0, 1, 32'h80FF_7F01);    idle(1);
    do_op(3'd1, 32'h0, 32'd0, 0, 32'h80FF_7F01);    idle(1);
    do_op(3'd2, 32'h2, 32'd0, 2, 32'h80FF_7F01);    idle(1);
    do_op(3'd0, 32'h6, 32'd0, 0, 32'd0);            idle(1);
    do_op(3'd6, 32'h5, 32'h1234_5678, 0, 32'd0);    idle(1);

    // Back-to-back: the SW is presented during the LW's DONE cycle.
    do_op(3'd0, 32'h20, 32'd0, 0, 32'h1357_9BDF);
    do_op(3'd5, 32'h24, 32'hCAFE_F00D, 0, 32'd0);
    idle(2);

    // Reset during BUSY, then a late ack.
    req_q.push_back('{we: 1'b0, addr: 32'h40, be: 4'hF, wdata: 32'd0});
    stall_q.push_back(3);
    wait_cfg = 10;
    op_valid = 1'b1; op_type = 3'd0; op_addr = 32'h40;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    reset = 1'b1; op_valid = 1'b0;
    @(posedge Clk); #1;
    reset = 1'b0; force_ack = 1'b1;
    chk("post_rst_req", 32'(mem_req), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    @(posedge Clk); #1;
    force_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    do_op(3'd0, 32'h44, 32'd0, 1, 32'h0BAD_F00D);   idle(1);

    // Randomized ops, alternating idle gaps with back-to-back issue.
    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom,
            int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(4);

    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("ev_q_empty", 32'(ev_q.size()), 32'd0);
    chk("stall_q_empty", 32'(stall_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store initiator: accepts one load/store per instruction from the pipeline and drives a word-addressed data memory over a req/ack handshake with variable latency.
- Generates byte enables and lane-replicated store data, and sign/zero-extends load data.
- Stalls the pipeline until the access completes; flags misaligned addresses instead of issuing them.

Parameters:
- ADDR_W, 32, byte-address width on both pipeline and memory sides.
- WORD_ADDR_LSB, 2, number of address LSBs forced to zero on mem_addr (word alignment).

Ports:
- Clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- op_valid  in  1  MEM-stage instruction is a load/store; held stable with op_* while stall=1
- op_type  in  3  LW=0 LH=1 LHU=2 LB=3 LBU=4 SW=5 SH=6 SB=7
- op_addr  in  ADDR_W  effective byte address
- op_wdata  in  32  store source register value
- stall  out  1  freeze IF..MEM and bubble WB while high
- ld_data  out  32  extended load result, valid when ld_valid=1
- ld_valid  out  1  one-cycle pulse, load result ready
- exc  out  1  one-cycle pulse, address exception
- exc_code  out  2  0 none, 1 AdEL (load), 2 AdES (store)
- mem_req  out  1  request to data memory
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  op_addr with low WORD_ADDR_LSB bits zeroed
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completes the request this cycle; mem_rdata valid when !mem_we
- mem_rdata  in  32  read word

Behaviour:
- Reset values: state=IDLE; stall, ld_valid, exc, mem_req, mem_we = 0; exc_code, mem_be = 0; ld_data, mem_addr, mem_wdata = 0.
- FSM states: IDLE, BUSY, DONE, FAULT.
- IDLE, no op_valid: stall=0, no activity. mem_ack is ignored.
- Alignment is misaligned when either holds:
  - LW/SW with addr[1:0]!=0;
  - LH/LHU/SH with addr[0]=1.
- IDLE, op_valid, aligned: stall=1 (combinational). Latch type, addr, be, and wdata into registers. Next state BUSY.
- IDLE, op_valid, misaligned: stall=1. Next state FAULT. No memory request is ever issued for a misaligned access.
- BUSY:
  - mem_req=1, and mem_we/mem_addr/mem_be/mem_wdata come from the latched registers, held constant.
  - stall=1.
  - When mem_ack=1: if the op is a load, register the extended mem_rdata into ld_data. Next state DONE.
  - mem_ack may arrive in the first BUSY cycle.
- DONE: stall=0, mem_req=0, ld_valid=1 for loads only (0 for stores). Next state IDLE. op_valid is ignored in this cycle because the pipeline advances at this edge.
- FAULT: stall=0, exc=1, exc_code=AdEL for loads or AdES for stores. Next state IDLE. op_valid is ignored.
- Minimum latency is 3 cycles (IDLE accept, BUSY+ack, DONE). Each extra memory wait cycle adds one.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{op_wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{op_wdata[15:0]}}.
  - SW: be = 4'b1111, wdata = op_wdata.
- Load lanes:
  - Loads drive be = 4'b1111.
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - LW passes the word through.
- ld_data holds its value until the next load completes.
- Reset mid-operation (any state): next cycle IDLE, mem_req drops, no ld_valid/exc pulse. A late mem_ack is ignored.
- A new op arriving while BUSY is not possible (stall held). The block does not queue.

Decomposition:
- Package mau_pkg: op_type encodings, FSM state enum, exc_code constants (EXC_NONE, EXC_ADEL, EXC_ADES).
- Sub-module lsu_align (purely combinational), reused on both paths:
  - inputs op_type, addr[1:0], op_wdata, mem_rdata;
  - outputs be, wdata_rep, ld_ext, misaligned.
- The FSM, registers, and handshake stay in mem_access_unit.

Test Plan:
- SW addr=0x0000_0010, wdata=0xDEADBEEF, ack in first BUSY cycle:
  - mem_req=1, mem_we=1, mem_addr=0x10, mem_be=4'b1111, mem_wdata=0xDEADBEEF;
  - stall high for 2 cycles, DONE in cycle 3 with ld_valid=0.
- SB addr=0x13, wdata=0x000000A5, ack after 3 wait cycles:
  - mem_be=4'b1000, mem_wdata=0xA5A5A5A5 held stable across the waits;
  - stall high for 5 cycles.
- mem_rdata=0x80FF7F01:
  - LB addr=0x2 -> ld_data=0xFFFFFFFF;
  - LBU addr=0x3 -> 0x00000080;
  - LH addr=0x0 -> 0x00007F01;
  - LHU addr=0x2 -> 0x000080FF;
  - ld_valid pulses 1 cycle in DONE for each.
- Misaligned accesses:
  - LW addr=0x6 -> exc=1 for one cycle, exc_code=1, mem_req never asserted;
  - SH addr=0x5 -> exc_code=2.
- reset asserted during BUSY, with mem_ack arriving the cycle after:
  - IDLE next cycle, mem_req=0, stall=0, no ld_valid;
  - a following LW executes normally.
- Back-to-back LW then SW, each with immediate ack: the second request is issued in the cycle after DONE, with no duplicate issue of the first.
